// File: rtl/gam_node_mem_arbiter_pkg.sv
// Shared types for the GAM node memory arbiter: memory command, arbiter state
// and requester index constants.
package gam_node_mem_arbiter_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } RD_WR_T;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } ARB_STATE_T;

    localparam int REQ_ML   = 0;
    localparam int REQ_AL   = 1;
    localparam int REQ_HOST = 2;

endpackage

// File: rtl/gam_node_mem_arbiter_if.sv
// Requester and memory-port bundle for the GAM node memory arbiter.
interface gam_node_mem_arbiter_if
    import gam_node_mem_arbiter_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // Handshake: requester i holds req[i] (with rd_wr/addr/wdata stable) until it
    // sees gnt[i]; the access happens in every gnt[i] cycle where req[i] is high.
    // lock[i] keeps the grant across cycles; read data returns with rvalid[i].
    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0]             lock;
    logic [N_REQ-1:0]             rd_wr;
    logic [N_REQ-1:0][ADDR_W-1:0] addr;
    logic [N_REQ-1:0][DATA_W-1:0] wdata;
    logic [N_REQ-1:0]             gnt;
    logic [N_REQ-1:0]             rvalid;
    logic [DATA_W-1:0]            rdata;

    logic                         mem_en;
    RD_WR_T                       mem_rd_wr;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wdata;
    logic [DATA_W-1:0]            mem_rdata;

    modport slave (
        input  req, lock, rd_wr, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_rd_wr, mem_addr, mem_wdata
    );

    modport master (
        output req, lock, rd_wr, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_rd_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/gam_arb_pick.sv
// Combinational winner selection; fixed priority (index 0 highest) by default,
// round-robin starting at ptr when GAM_ARB_RR_EN is defined.
module gam_arb_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] excl,
`ifdef GAM_ARB_RR_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic [N_REQ-1:0] win,
    output logic             valid
);
    logic [N_REQ-1:0] cand;

    assign cand = req & ~excl;

    always_comb begin
        int k;
        win   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef GAM_ARB_RR_EN
            k = (int'(ptr) + i) % N_REQ;
`else
            k = i;
`endif
            if (!valid && cand[k]) begin
                win[k] = 1'b1;
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gam_node_mem_arbiter.sv
// Single-port GAM node memory arbiter with locked bursts and a burst cap.
// GAM_ARB_RR_EN selects round-robin picking instead of fixed priority.
module gam_node_mem_arbiter
    import gam_node_mem_arbiter_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    gam_node_mem_arbiter_if.slave   bus,
    output ARB_STATE_T              dbg_state,
    output logic [4:0]              dbg_burst_cnt
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    ARB_STATE_T        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [4:0]        burst_q, burst_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;

    logic              owner_req, owner_lock, others_req, at_cap, keep;
    logic [N_REQ-1:0]  excl, pick_win;
    logic              pick_valid;
    logic              mem_en;
    RD_WR_T            m_rd_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;

`ifdef GAM_ARB_RR_EN
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

    // gnt_q is the one-hot owner; it is all-zero exactly when IDLE.
    always_comb begin
        owner_req  = |(bus.req & gnt_q);
        owner_lock = |(bus.lock & gnt_q);
        others_req = |(bus.req & ~gnt_q);
        at_cap     = burst_q >= 5'(MAX_BURST - 1);
        keep       = (state_q == ARB_GRANT) && owner_req && owner_lock
                     && !(at_cap && others_req);
        excl       = ((state_q == ARB_GRANT) && owner_req && owner_lock && !keep)
                     ? gnt_q : '0;
    end

    gam_arb_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (bus.req),
        .excl  (excl),
`ifdef GAM_ARB_RR_EN
        .ptr   (rr_ptr_q),
`endif
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        burst_d = burst_q;
        if (keep) begin
            if (burst_q < 5'(MAX_BURST)) burst_d = burst_q + 5'd1;
        end else if (pick_valid) begin
            state_d = ARB_GRANT;
            gnt_d   = pick_win;
            burst_d = '0;
        end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            burst_d = '0;
        end
    end

    always_comb begin
        mem_en  = (state_q == ARB_GRANT) && owner_req;
        m_rd_wr = READ;
        m_addr  = '0;
        m_wdata = '0;
        if (mem_en) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_q[i]) begin
                    m_rd_wr = RD_WR_T'(bus.rd_wr[i]);
                    m_addr  = bus.addr[i];
                    m_wdata = bus.wdata[i];
                end
            end
        end
        rvalid_d = (mem_en && m_rd_wr == READ) ? gnt_q : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= '0;
            burst_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            burst_q  <= burst_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef GAM_ARB_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!keep && pick_valid) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (pick_win[i]) rr_ptr_d = IDX_W'((i + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_en    = mem_en;
    assign bus.mem_rd_wr = m_rd_wr;
    assign bus.mem_addr  = m_addr;
    assign bus.mem_wdata = m_wdata;
    assign dbg_state     = state_q;
    assign dbg_burst_cnt = burst_q;
endmodule

// File: tb/tb_gam_node_mem_arbiter.sv
// Directed bench for gam_node_mem_arbiter: reset, single read, simultaneous
// requests, burst cap, lone locked burst, owner drop and reset mid-burst.
module tb_gam_node_mem_arbiter;
    import gam_node_mem_arbiter_pkg::*;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic       clk;
    logic       reset;
    ARB_STATE_T dbg_state;
    logic [4:0] dbg_burst_cnt;
    int         tests;
    int         failed;

    gam_node_mem_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    gam_node_mem_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .dbg_state     (dbg_state),
        .dbg_burst_cnt (dbg_burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_g2 [4];
    logic [7:0] exp_a2 [4];

    initial begin
        tests  = 0;
        failed = 0;
`ifdef GAM_ARB_RR_EN
        exp_g2 = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_a2 = '{8'h20, 8'h21, 8'h22, 8'h20};
`else
        exp_g2 = '{3'b001, 3'b001, 3'b001, 3'b001};
        exp_a2 = '{8'h20, 8'h20, 8'h20, 8'h20};
`endif

        // Reset held with requests active: nothing may be granted.
        reset         = 1'b0;
        bus.req       = 3'b111;
        bus.lock      = 3'b111;
        bus.rd_wr     = 3'b000;
        bus.addr[0]   = 8'h20;
        bus.addr[1]   = 8'h21;
        bus.addr[2]   = 8'h22;
        bus.wdata[0]  = 32'hA000_0000;
        bus.wdata[1]  = 32'hA111_1111;
        bus.wdata[2]  = 32'hA222_2222;
        bus.mem_rdata = 32'hCAFE_0012;
        #12;
        chk("rst_gnt",    64'(bus.gnt), 64'(3'b000));
        chk("rst_mem_en", 64'(bus.mem_en), 64'(1'b0));
        chk("rst_rd_wr",  64'(bus.mem_rd_wr), 64'(READ));
        chk("rst_addr",   64'(bus.mem_addr), 64'(8'h00));
        chk("rst_wdata",  64'(bus.mem_wdata), 64'(32'h0));
        chk("rst_rvalid", 64'(bus.rvalid), 64'(3'b000));
        chk("rst_state",  64'(dbg_state), 64'(ARB_IDLE));
        chk("rst_burst",  64'(dbg_burst_cnt), 64'(5'd0));
        chk("rst_rdata",  64'(bus.rdata), 64'(32'hCAFE_0012));
        @(negedge clk);
        reset    = 1'b1;
        bus.req  = 3'b000;
        bus.lock = 3'b000;

        // Simultaneous unlocked writes from all three requesters.
        cyc();
        bus.req   = 3'b111;
        bus.rd_wr = 3'b111;
        #3;
        chk("sim_gnt_lat", 64'(bus.gnt), 64'(3'b000));
        for (int i = 0; i < 4; i++) begin
            cyc();
            #3;
            chk("sim_gnt",    64'(bus.gnt), 64'(exp_g2[i]));
            chk("sim_addr",   64'(bus.mem_addr), 64'(exp_a2[i]));
            chk("sim_rd_wr",  64'(bus.mem_rd_wr), 64'(WRITE));
            chk("sim_rvalid", 64'(bus.rvalid), 64'(3'b000));
        end
        chk("sim_wdata", 64'(bus.mem_wdata), 64'(32'hA000_0000));
        cyc();
        bus.req = 3'b000;
        #3;
        chk("sim_drop_en", 64'(bus.mem_en), 64'(1'b0));
        cyc();
        #3;
        chk("sim_idle_gnt", 64'(bus.gnt), 64'(3'b000));

        // Single read by the associative layer.
        bus.rd_wr   = 3'b000;
        bus.addr[1] = 8'h12;
        cyc();
        bus.req = 3'b010;
        #3;
        chk("rd_gnt_lat", 64'(bus.gnt), 64'(3'b000));
        cyc();
        #3;
        chk("rd_gnt",    64'(bus.gnt), 64'(3'b010));
        chk("rd_en",     64'(bus.mem_en), 64'(1'b1));
        chk("rd_addr",   64'(bus.mem_addr), 64'(8'h12));
        chk("rd_rd_wr",  64'(bus.mem_rd_wr), 64'(READ));
        chk("rd_rv_early", 64'(bus.rvalid), 64'(3'b000));
        cyc();
        bus.req = 3'b000;
        #3;
        chk("rd_gnt_hold", 64'(bus.gnt), 64'(3'b010));
        chk("rd_en_drop",  64'(bus.mem_en), 64'(1'b0));
        chk("rd_idle_addr", 64'(bus.mem_addr), 64'(8'h00));
        chk("rd_rvalid",   64'(bus.rvalid), 64'(3'b010));
        chk("rd_rdata",    64'(bus.rdata), 64'(32'hCAFE_0012));
        cyc();
        #3;
        chk("rd_end_gnt",  64'(bus.gnt), 64'(3'b000));
        chk("rd_end_rv",   64'(bus.rvalid), 64'(3'b000));
        chk("rd_end_state", 64'(dbg_state), 64'(ARB_IDLE));

        // Burst cap: locked reads by 0 while host waits.
        bus.addr[1] = 8'h21;
        cyc();
        bus.req  = 3'b001;
        bus.lock = 3'b001;
        #3;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            bus.req = 3'b101;
            #3;
            chk("cap_gnt",   64'(bus.gnt), 64'(3'b001));
            chk("cap_en",    64'(bus.mem_en), 64'(1'b1));
            chk("cap_burst", 64'(dbg_burst_cnt), 64'(i - 1));
        end
        cyc();
        bus.mem_rdata = 32'h0BAD_F00D;
        #3;
        chk("cap_host_gnt",  64'(bus.gnt), 64'(3'b100));
        chk("cap_host_addr", 64'(bus.mem_addr), 64'(8'h22));
        chk("cap_rv0",       64'(bus.rvalid), 64'(3'b001));
        cyc();
        bus.req = 3'b001;
        #3;
        chk("cap_back_gnt", 64'(bus.gnt), 64'(3'b001));
        chk("cap_back_burst", 64'(dbg_burst_cnt), 64'(5'd0));
        chk("cap_rv2",      64'(bus.rvalid), 64'(3'b100));
        chk("cap_rdata",    64'(bus.rdata), 64'(32'h0BAD_F00D));
        cyc();
        bus.req  = 3'b000;
        bus.lock = 3'b000;
        #3;
        chk("cap_drop_en", 64'(bus.mem_en), 64'(1'b0));
        cyc();
        #3;
        chk("cap_idle_gnt", 64'(bus.gnt), 64'(3'b000));

        // Locked writes by requester 1 alone: grant held, counter saturates.
        cyc();
        bus.req   = 3'b010;
        bus.lock  = 3'b010;
        bus.rd_wr = 3'b010;
        #3;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            #3;
            chk("lone_gnt",   64'(bus.gnt), 64'(3'b010));
            chk("lone_wdata", 64'(bus.mem_wdata), 64'(32'hA111_1111));
            chk("lone_burst", 64'(dbg_burst_cnt), 64'((i - 1 > 16) ? 16 : i - 1));
            chk("lone_rv",    64'(bus.rvalid), 64'(3'b000));
        end
        cyc();
        bus.req  = 3'b000;
        bus.lock = 3'b000;
        #3;
        chk("lone_drop_gnt", 64'(bus.gnt), 64'(3'b010));
        chk("lone_drop_en",  64'(bus.mem_en), 64'(1'b0));
        cyc();
        #3;
        chk("lone_idle", 64'(bus.gnt), 64'(3'b000));

        // Locked owner drops its request with host pending.
        bus.rd_wr = 3'b000;
        cyc();
        bus.req  = 3'b010;
        bus.lock = 3'b010;
        #3;
        cyc();
        bus.req = 3'b110;
        #3;
        chk("drop_gnt1", 64'(bus.gnt), 64'(3'b010));
        cyc();
        bus.req = 3'b100;
        #3;
        chk("drop_gnt_hold", 64'(bus.gnt), 64'(3'b010));
        chk("drop_en",       64'(bus.mem_en), 64'(1'b0));
        chk("drop_rv",       64'(bus.rvalid), 64'(3'b010));
        cyc();
        bus.lock = 3'b000;
        #3;
        chk("drop_next_gnt", 64'(bus.gnt), 64'(3'b100));
        chk("drop_next_addr", 64'(bus.mem_addr), 64'(8'h22));
        chk("drop_no_rv",    64'(bus.rvalid), 64'(3'b000));
        cyc();
        bus.req = 3'b000;
        #3;
        chk("drop_host_rv", 64'(bus.rvalid), 64'(3'b100));
        cyc();
        #3;
        chk("drop_idle", 64'(bus.gnt), 64'(3'b000));

        // Reset asserted in the middle of a locked read burst.
        cyc();
        bus.req  = 3'b001;
        bus.lock = 3'b001;
        #3;
        cyc();
        #3;
        chk("mrst_gnt", 64'(bus.gnt), 64'(3'b001));
        cyc();
        #3;
        chk("mrst_rv_pre", 64'(bus.rvalid), 64'(3'b001));
        #1;
        reset = 1'b0;
        #1;
        chk("mrst_gnt0",  64'(bus.gnt), 64'(3'b000));
        chk("mrst_en0",   64'(bus.mem_en), 64'(1'b0));
        chk("mrst_rv0",   64'(bus.rvalid), 64'(3'b000));
        chk("mrst_state", 64'(dbg_state), 64'(ARB_IDLE));
        cyc();
        chk("mrst_hold_gnt", 64'(bus.gnt), 64'(3'b000));
        chk("mrst_hold_rv",  64'(bus.rvalid), 64'(3'b000));
        #2;
        reset = 1'b1;
        cyc();
        #3;
        chk("mrst_regnt", 64'(bus.gnt), 64'(3'b001));
        chk("mrst_reen",  64'(bus.mem_en), 64'(1'b1));
        chk("mrst_rv_gone", 64'(bus.rvalid), 64'(3'b000));
        cyc();
        bus.req  = 3'b000;
        bus.lock = 3'b000;
        cyc();
        #3;
        chk("final_idle", 64'(bus.gnt), 64'(3'b000));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
